crc_checker: RTL and testbench
==============================

Name: crc_checker

Overview:
- Bit-serial receive-side CRC checker.
- Consumes a codeword of MSG_W message bits followed by CRC_W check bits, MSB first.
- Divides the codeword by the generator using an LFSR and delivers the recovered message with a syndrome and an error flag over a valid/ready output.
- Sits directly downstream of the CRC encoder and the serial link: it checks what the encoder produced.

Parameters:
- MSG_W, 7, message bits per codeword
- CRC_W, 3, check bits per codeword; equals the generator degree
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- gp  in  CRC_W  generator low coefficients (implicit x^CRC_W term); default use 3'b011 = x^3+x+1
- clr  in  1  synchronous abort of the in-progress frame
- s_bit  in  1  serial codeword bit, MSB first
- s_valid  in  1  s_bit valid
- s_ready  out  1  checker can accept a bit
- m_msg  out  MSG_W  recovered message bits
- m_syndrome  out  CRC_W  remainder of codeword mod G
- m_err  out  1  syndrome non-zero
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts the result
- err_cnt  out  CNT_W  count of frames with m_err=1, saturating

Behaviour:
- Reset values: all outputs 0, except s_ready=1 from the first cycle after reset. Internal bit counter=0, rem=0, shift register=0, state=RECV.
- States:
  - RECV: s_ready=1, m_valid=0.
  - HOLD: s_ready=0, m_valid=1.
- Bit acceptance: s_valid & s_ready in RECV. On each accepted bit:
  - rem_next = {rem[CRC_W-2:0], s_bit} ^ (rem[CRC_W-1] ? gp_lat : 0)
  - The shift register shifts s_bit in at the LSB.
  - The bit counter increments.
- gp is latched into gp_lat when the first bit of a frame is accepted (counter==0), and that bit already uses the incoming gp value. gp changes mid-frame have no effect.
- Frame completion:
  - Trigger: the bit with counter==MSG_W+CRC_W-1 is accepted.
  - Next cycle: state=HOLD, m_valid=1.
  - m_msg = the first MSG_W bits received, first-received bit in m_msg[MSG_W-1].
  - m_syndrome = final rem; m_err = |final rem.
  - Counter and rem return to 0.
  - Latency is 1 cycle from the last bit to m_valid.
- err_cnt increments in the same cycle m_valid rises when m_err=1. It saturates at 2^CNT_W-1, and only rst clears it.
- HOLD:
  - Outputs stay stable until m_valid & m_ready.
  - On that handshake cycle: next state=RECV, m_valid=0 the next cycle, s_ready=1 the next cycle. There is one bubble cycle per frame; no bit is accepted in the handshake cycle.
- clr:
  - In RECV: clears the counter and rem and drops any bit accepted that cycle; clr wins over s_valid.
  - In HOLD: ignored; the pending result is kept.
  - Does not touch err_cnt.
- s_valid low mid-frame: the frame pauses with no timeout; the state is retained indefinitely.
- rst mid-frame or in HOLD: the partial frame and pending result are discarded, and all reset values apply the next cycle.
- Width rules:
  - Counter width = clog2(MSG_W+CRC_W).
  - The LFSR is exactly CRC_W bits, with no carry beyond bit CRC_W-1.

Decomposition:
- Shared package crc_pkg:
  - MSG_W/CRC_W defaults
  - CW_W = MSG_W+CRC_W
  - default generator constant GP_DEFAULT=3'b011
  - state enum {RECV, HOLD}
- One natural sub-module: crc_lfsr_step. It is a combinational single-bit division step (rem, bit, gp -> rem_next) and is reusable by a future serial encoder.
- Handshake, counter and output registers stay in crc_checker.

Test Plan:
- Clean frame: gp=011, bits 1000000_100 streamed back-to-back, m_ready=1 → one cycle after the 10th bit m_valid=1, m_msg=7'h40, m_syndrome=000, m_err=0, err_cnt=0.
- Single-bit error: same frame with the last bit flipped (1000000_101) → m_syndrome=001, m_err=1, err_cnt=1. Run an exhaustive single-bit flip over all 10 positions; every flip gives a non-zero syndrome.
- Backpressure: m_ready=0 for 5 cycles after a frame → m_valid and outputs stay stable, s_ready=0, and a bit offered during HOLD is not consumed. Release m_ready → m_valid drops the next cycle and s_ready=1.
- Abort/pause:
  - s_valid gaps inside a frame → same result as the gap-free run.
  - clr asserted after 4 bits, together with s_valid → that bit is dropped, and the following clean 10-bit frame checks clean.
- gp latch and saturation:
  - gp changed mid-frame → result uses the gp present at the first bit.
  - CNT_W=2 build with 5 erroneous frames → err_cnt stops at 3.
- Reset mid-frame: rst after 6 bits → all outputs 0 and s_ready=1 next cycle; a subsequent all-zero frame gives m_msg=0, m_err=0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared constants and types for the bit-serial CRC checker.
// Default generator is x^3+x+1 with the x^3 term implicit.
package crc_pkg;

    localparam int MSG_W_DEF = 7;
    localparam int CRC_W_DEF = 3;
    localparam int CW_W_DEF  = MSG_W_DEF + CRC_W_DEF;

    localparam logic [CRC_W_DEF-1:0] GP_DEFAULT = 3'b011;

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit of polynomial long division: shift a bit into the
// remainder and subtract the generator when the top bit falls out.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int CRC_W = CRC_W_DEF
) (
    input  logic [CRC_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [CRC_W-1:0] gp_i,
    output logic [CRC_W-1:0] rem_o
);

    assign rem_o = {rem_i[CRC_W-2:0], bit_i}
                 ^ (rem_i[CRC_W-1] ? gp_i : '0);

endmodule

// File: rtl/crc_checker.sv
// Bit-serial receive-side CRC checker: divides each codeword by the
// generator and hands message, syndrome and error flag downstream.
module crc_checker
    import crc_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEF,
    parameter int CRC_W = CRC_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CRC_W-1:0] gp,
    input  logic             clr,
    input  logic             s_bit,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [MSG_W-1:0] m_msg,
    output logic [CRC_W-1:0] m_syndrome,
    output logic             m_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CW_W  = MSG_W + CRC_W;
    localparam int CTR_W = $clog2(CW_W);
    localparam int SR_W  = CW_W - 1;

    localparam logic [CTR_W-1:0] LAST_BIT = CTR_W'(CW_W - 1);
    localparam logic [CNT_W-1:0] ECNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic [CRC_W-1:0] rem_q, rem_d;
    logic [CRC_W-1:0] gp_lat_q, gp_lat_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [CRC_W-1:0] syn_q, syn_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic [CRC_W-1:0] gp_use;
    logic [CRC_W-1:0] rem_nxt;

    // First bit of a frame divides by the live gp; later bits by the latched copy.
    assign gp_use = (cnt_q == '0) ? gp : gp_lat_q;

    crc_lfsr_step #(
        .CRC_W (CRC_W)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (s_bit),
        .gp_i  (gp_use),
        .rem_o (rem_nxt)
    );

    // Next-state logic: bit acceptance, frame completion and result handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        gp_lat_d = gp_lat_q;
        sr_d     = sr_q;
        msg_d    = msg_q;
        syn_d    = syn_q;
        err_d    = err_q;
        ecnt_d   = ecnt_q;
        unique case (state_q)
            RECV: begin
                if (clr) begin
                    cnt_d = '0;
                    rem_d = '0;
                    sr_d  = '0;
                end else if (s_valid) begin
                    if (cnt_q == '0) begin
                        gp_lat_d = gp;
                    end
                    sr_d = {sr_q[SR_W-2:0], s_bit};
                    if (cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        rem_d   = '0;
                        msg_d   = sr_q[SR_W-1:CRC_W-1];
                        syn_d   = rem_nxt;
                        err_d   = |rem_nxt;
                        if ((|rem_nxt) && (ecnt_q != ECNT_MAX)) begin
                            ecnt_d = ecnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CTR_W'(1);
                        rem_d = rem_nxt;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RECV;
            cnt_q    <= '0;
            rem_q    <= '0;
            gp_lat_q <= '0;
            sr_q     <= '0;
            msg_q    <= '0;
            syn_q    <= '0;
            err_q    <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            gp_lat_q <= gp_lat_d;
            sr_q     <= sr_d;
            msg_q    <= msg_d;
            syn_q    <= syn_d;
            err_q    <= err_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign s_ready    = (state_q == RECV);
    assign m_valid    = (state_q == HOLD);
    assign m_msg      = msg_q;
    assign m_syndrome = syn_q;
    assign m_err      = err_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker with generator x^3+x+1.
// A second instance with a 2-bit error counter shares all inputs.
module tb_crc_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] gp;
    logic       clr;
    logic       s_bit;
    logic       s_valid;
    logic       m_ready;

    logic       s_ready, m_err, m_valid;
    logic [6:0] m_msg;
    logic [2:0] m_syndrome;
    logic [7:0] err_cnt;

    logic       s_ready2, m_err2, m_valid2;
    logic [6:0] m_msg2;
    logic [2:0] m_syndrome2;
    logic [1:0] err_cnt2;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    // x^e mod (x^3+x+1) for e = 0..6; the sequence repeats with period 7
    logic [2:0] syn_tab [7] = '{3'b001, 3'b010, 3'b100, 3'b011,
                                3'b110, 3'b111, 3'b101};

    localparam logic [9:0] CW_A = 10'b1000000_100;
    localparam logic [9:0] CW_B = 10'b0000001_011;

    always #5 clk = ~clk;

    crc_checker dut (
        .clk        (clk),
        .rst        (rst),
        .gp         (gp),
        .clr        (clr),
        .s_bit      (s_bit),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_msg      (m_msg),
        .m_syndrome (m_syndrome),
        .m_err      (m_err),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .err_cnt    (err_cnt)
    );

    crc_checker #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .gp         (gp),
        .clr        (clr),
        .s_bit      (s_bit),
        .s_valid    (s_valid),
        .s_ready    (s_ready2),
        .m_msg      (m_msg2),
        .m_syndrome (m_syndrome2),
        .m_err      (m_err2),
        .m_valid    (m_valid2),
        .m_ready    (m_ready),
        .err_cnt    (err_cnt2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream a codeword MSB first; optional two-cycle gaps inside it
    task automatic send_cw(input logic [9:0] cw, input bit gaps);
        for (int i = 9; i >= 0; i--) begin
            s_bit   = cw[i];
            s_valid = 1'b1;
            step();
            if (gaps && (i % 3 == 1)) begin
                s_valid = 1'b0;
                step();
                step();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; s_bit = 1'b0; s_valid = 1'b0;
        m_ready = 1'b1; gp = 3'b011;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({s_ready, m_valid, m_msg, m_syndrome, m_err, err_cnt} !==
            {1'b1, 1'b0, 7'h00, 3'b000, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b msg=%h syn=%b err=%b cnt=%0d want rdy=1 rest 0",
                     s_ready, m_valid, m_msg, m_syndrome, m_err, err_cnt);
        end
        checks++;
        if (err_cnt2 !== 2'd0 || s_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset2: cnt=%0d rdy=%b want 0 1", err_cnt2, s_ready2);
        end
    endtask

    task automatic test_clean();
        send_cw(CW_A, 1'b0);
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err} !==
            {1'b1, 7'h40, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL clean: vld=%b msg=%h syn=%b err=%b want 1 40 000 0",
                     m_valid, m_msg, m_syndrome, m_err);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clean_cnt: got %0d want 0", err_cnt);
        end
        step();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL clean_hs: vld=%b rdy=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_single_err();
        send_cw(10'b1000000_101, 1'b0);
        exp_cnt++;
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err, err_cnt} !==
            {1'b1, 7'h40, 3'b001, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL single_err: vld=%b msg=%h syn=%b err=%b cnt=%0d want 1 40 001 1 1",
                     m_valid, m_msg, m_syndrome, m_err, err_cnt);
        end
        step();
    endtask

    task automatic test_flip_all();
        for (int p = 0; p < 10; p++) begin
            int         e;
            int         sat;
            logic [9:0] cw;
            logic [6:0] emsg;
            e    = 9 - p;
            cw   = CW_A ^ (10'd1 << e);
            emsg = 7'h40;
            if (e >= 3) emsg = emsg ^ (7'd1 << (e - 3));
            send_cw(cw, 1'b0);
            exp_cnt++;
            sat = (exp_cnt > 3) ? 3 : exp_cnt;
            checks++;
            if ({m_valid, m_msg, m_syndrome, m_err} !==
                {1'b1, emsg, syn_tab[e % 7], 1'b1}) begin
                errors++;
                $display("FAIL flip%0d: vld=%b msg=%h syn=%b err=%b want 1 %h %b 1",
                         p, m_valid, m_msg, m_syndrome, m_err, emsg, syn_tab[e % 7]);
            end
            checks++;
            if (err_cnt !== 8'(exp_cnt) || err_cnt2 !== sat[1:0]) begin
                errors++;
                $display("FAIL flip%0d_cnt: cnt=%0d cnt2=%0d want %0d %0d",
                         p, err_cnt, err_cnt2, exp_cnt, sat);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_cw(CW_A, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: vld=%b rdy=%b want 1 0", m_valid, s_ready);
        end
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_bit   = 1'b1;
            clr     = (k == 2);
            step();
            checks++;
            if ({m_valid, s_ready, m_msg, m_syndrome, m_err} !==
                {1'b1, 1'b0, 7'h40, 3'b000, 1'b0}) begin
                errors++;
                $display("FAIL bp_stable%0d: vld=%b rdy=%b msg=%h syn=%b err=%b want 1 0 40 000 0",
                         k, m_valid, s_ready, m_msg, m_syndrome, m_err);
            end
        end
        clr     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", m_valid, s_ready);
        end
        send_cw(CW_A, 1'b0);
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err} !==
            {1'b1, 7'h40, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL bp_next: vld=%b msg=%h syn=%b err=%b want 1 40 000 0",
                     m_valid, m_msg, m_syndrome, m_err);
        end
        step();
    endtask

    task automatic test_gaps();
        send_cw(CW_B, 1'b1);
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err} !==
            {1'b1, 7'h01, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL gaps: vld=%b msg=%h syn=%b err=%b want 1 01 000 0",
                     m_valid, m_msg, m_syndrome, m_err);
        end
        step();
    endtask

    task automatic test_clr();
        logic [3:0] pre;
        pre = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            s_bit   = pre[i];
            s_valid = 1'b1;
            step();
        end
        s_bit = 1'b1;
        clr   = 1'b1;
        step();
        clr     = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_state: vld=%b rdy=%b want 0 1", m_valid, s_ready);
        end
        send_cw(CW_B, 1'b0);
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err} !==
            {1'b1, 7'h01, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL clr_frame: vld=%b msg=%h syn=%b err=%b want 1 01 000 0",
                     m_valid, m_msg, m_syndrome, m_err);
        end
        step();
    endtask

    task automatic test_gp_latch();
        for (int i = 9; i >= 0; i--) begin
            s_bit   = CW_B[i];
            s_valid = 1'b1;
            step();
            gp = 3'b101;
        end
        s_valid = 1'b0;
        gp      = 3'b011;
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err} !==
            {1'b1, 7'h01, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL gp_latch: vld=%b msg=%h syn=%b err=%b want 1 01 000 0",
                     m_valid, m_msg, m_syndrome, m_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            s_bit   = 1'b1;
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 0;
        checks++;
        if ({s_ready, m_valid, m_msg, m_syndrome, m_err, err_cnt, err_cnt2} !==
            {1'b1, 1'b0, 7'h00, 3'b000, 1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL rst_mid: rdy=%b vld=%b msg=%h syn=%b err=%b cnt=%0d cnt2=%0d want 1 then 0s",
                     s_ready, m_valid, m_msg, m_syndrome, m_err, err_cnt, err_cnt2);
        end
        send_cw(10'b0, 1'b0);
        checks++;
        if ({m_valid, m_msg, m_syndrome, m_err, err_cnt} !==
            {1'b1, 7'h00, 3'b000, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rst_zero: vld=%b msg=%h syn=%b err=%b cnt=%0d want 1 00 000 0 0",
                     m_valid, m_msg, m_syndrome, m_err, err_cnt);
        end
        step();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean();
        test_single_err();
        test_flip_all();
        test_backpressure();
        test_gaps();
        test_clr();
        test_gp_latch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
